fsa_root_node: RTL

//  Root (parent) end of the Fair-Switch-Arbiter tree. Collects up_req from
//  N_LEAF leaf nodes and issues a one-cycle one-hot ack to the winner. Holds
//  the switch path until the downstream transfer signals done. Issues the

---
 rtl/fsa_root_node_if.sv | 27 ++
 rtl/fsa_root_node.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fsa_root_node_if.sv
// Purpose : bundle of leaf-side and transfer-side signals of the FSA root node.
// Ports   : leaf_req/xfer_done driven by the leaves and downstream transfer logic,
//           leaf_ack/update/busy/sel_leaf/err_timeout driven by the root node.
// Modports: master = root node side, slave = leaf/transfer side.
interface fsa_root_node_if #(
  parameter int unsigned N_LEAF = 4
);
  localparam int unsigned SEL_W = $clog2(N_LEAF);

  logic [N_LEAF-1:0] leaf_req;
  logic [N_LEAF-1:0] leaf_ack;
  logic              update;
  logic              busy;
  logic [SEL_W-1:0]  sel_leaf;
  logic              xfer_done;
  logic              err_timeout;

  modport master (
    input  leaf_req, xfer_done,
    output leaf_ack, update, busy, sel_leaf, err_timeout
  );

  modport slave (
    output leaf_req, xfer_done,
    input  leaf_ack, update, busy, sel_leaf, err_timeout
  );
endinterface

// File: rtl/fsa_root_node.sv
// Purpose : root node of the Fair-Switch-Arbiter tree. Picks one requesting
//           leaf with a rotating priority, acks it for one cycle, holds the
//           switch path until the transfer completes, and pulses a global
//           lock-clear (update) once an epoch has been served and no leaf asks.
// Ports   : clk, rst_n (async, active-low)
//           bus (fsa_root_node_if.master): leaf_req, xfer_done in;
//           leaf_ack, update, busy, sel_leaf, err_timeout out (all registered).
// Config  : FSA_TIMEOUT_EN enables the BUSY watchdog (TIMEOUT_CYC cycles);
//           without it err_timeout is tied low and BUSY waits for xfer_done.
module fsa_root_node #(
  parameter int unsigned       N_LEAF      = 4,
  parameter logic [N_LEAF-1:0] INIT_PTR    = N_LEAF'(1),
  parameter int unsigned       TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fsa_root_node_if.master       bus
);

  localparam int unsigned SEL_W = $clog2(N_LEAF);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;
  localparam logic [1:0] S_UPD  = 2'd3;

  // Elaboration-time guard on the supported parameter range.
  if (N_LEAF < 2 || N_LEAF > 16 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("fsa_root_node: parameter out of range");
  end

  logic [1:0]        state_q,    state_d;
  logic [N_LEAF-1:0] ptr_q,      ptr_d;
  logic              served_q,   served_d;
  logic [N_LEAF-1:0] leaf_ack_q, leaf_ack_d;
  logic              update_q,   update_d;
  logic              busy_q,     busy_d;
  logic [SEL_W-1:0]  sel_q,      sel_d;

`ifdef FSA_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  // Rotating-priority winner: ptr bit k set means search k-1, k-2, ... k.
  logic [N_LEAF-1:0] ptr_eff;
  logic [SEL_W-1:0]  ptr_idx;
  logic [SEL_W-1:0]  cand;
  logic              found;
  logic [N_LEAF-1:0] win_oh;
  logic [SEL_W-1:0]  win_idx;

  always_comb begin : winner_pick
    ptr_eff = $onehot(ptr_q) ? ptr_q : INIT_PTR;
    ptr_idx = '0;
    for (int unsigned j = 0; j < N_LEAF; j++) begin
      if (ptr_eff[j]) ptr_idx = SEL_W'(j);
    end
    found   = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_LEAF; i++) begin
      cand = SEL_W'((32'(ptr_idx) + N_LEAF - i) % N_LEAF);
      if (!found && bus.leaf_req[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin : fsm_next
    state_d    = state_q;
    ptr_d      = ptr_q;
    served_d   = served_q;
    sel_d      = sel_q;
    leaf_ack_d = '0;
    update_d   = 1'b0;
    busy_d     = 1'b0;
`ifdef FSA_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A pending request wins over the epoch update.
        if (|bus.leaf_req) begin
          leaf_ack_d = win_oh;
          sel_d      = win_idx;
          busy_d     = 1'b1;
          state_d    = S_ACK;
        end else if (served_q) begin
          update_d   = 1'b1;
          state_d    = S_UPD;
        end
      end
      S_ACK: begin
        ptr_d    = leaf_ack_q;
        served_d = 1'b1;
        busy_d   = 1'b1;
        state_d  = S_BUSY;
`ifdef FSA_TIMEOUT_EN
        cnt_d    = '0;
`endif
      end
      S_BUSY: begin
        busy_d = 1'b1;
        if (bus.xfer_done) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
`ifdef FSA_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_UPD: begin
        served_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= INIT_PTR;
      served_q   <= 1'b0;
      leaf_ack_q <= '0;
      update_q   <= 1'b0;
      busy_q     <= 1'b0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      served_q   <= served_d;
      leaf_ack_q <= leaf_ack_d;
      update_q   <= update_d;
      busy_q     <= busy_d;
      sel_q      <= sel_d;
    end
  end

`ifdef FSA_TIMEOUT_EN
  // BUSY watchdog counter and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin : wdog_regs
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.leaf_ack = leaf_ack_q;
  assign bus.update   = update_q;
  assign bus.busy     = busy_q;
  assign bus.sel_leaf = sel_q;

endmodule
